// File: rtl/raven_uno_pkg.sv
// raven_uno_pkg
//   Shared types and constants for the unary-op Horner sequencer.
//   - uno_op_e    : request opcode (GEMM / DIV / EXP / LOG)
//   - uno_state_e : sequencer FSM states
//   - COEF_*      : polynomial coefficients per unary op, index i is the
//                   coefficient of x^i, Q(INT.FRA) signed, COEF_W bits wide.
//                   Index UNO_DEPTH is the leading coefficient that seeds mac.
package raven_uno_pkg;

  localparam int UNO_INT_BW = 5;
  localparam int UNO_FRA_BW = 4;
  localparam int UNO_MUL_BW = 16;
  localparam int UNO_ACC_BW = 32;
  localparam int UNO_DEPTH  = 8;
  localparam int UNO_ROWS   = 1;

  // Sign bit + integer bits + fraction bits.
  localparam int COEF_W = UNO_INT_BW + UNO_FRA_BW + 1;

  typedef enum logic [1:0] {
    OP_GEMM = 2'b00,
    OP_DIV  = 2'b01,
    OP_EXP  = 2'b10,
    OP_LOG  = 2'b11
  } uno_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STREAM,
    ST_DRAIN
  } uno_state_e;

  typedef logic signed [COEF_W-1:0] coef_t;

  // 1/(1+x): alternating +1/-1 (16 = 1.0 in Q.4).
  localparam coef_t COEF_DIV [UNO_DEPTH+1] = '{
    10'sd16, -10'sd16, 10'sd16, -10'sd16, 10'sd16,
    -10'sd16, 10'sd16, -10'sd16, 10'sd16
  };

  // exp(x): Taylor terms 1, 1, 1/2, 1/6, 1/24, rest below one LSB.
  localparam coef_t COEF_EXP [UNO_DEPTH+1] = '{
    10'sd16, 10'sd16, 10'sd8, 10'sd3, 10'sd1,
    10'sd0, 10'sd0, 10'sd0, 10'sd0
  };

  // log(1+x): 0, 1, -1/2, 1/3, -1/4, 1/5, -1/6, 1/7, -1/8 rounded to Q.4.
  localparam coef_t COEF_LOG [UNO_DEPTH+1] = '{
    10'sd0, 10'sd16, -10'sd8, 10'sd5, -10'sd4,
    10'sd3, -10'sd3, 10'sd2, -10'sd2
  };

endpackage

// File: rtl/uno_coef_rom.sv
// uno_coef_rom
//   Combinational lookup of the DEPTH+1 Horner coefficients for one op.
//   Ports:
//     op_i   : requested unary op (GEMM returns all zeros)
//     coef_o : coefficient i of x^i in slice i
module uno_coef_rom
  import raven_uno_pkg::*;
(
  input  uno_op_e                          op_i,
  output logic [UNO_DEPTH:0][COEF_W-1:0]   coef_o
);

  // Table select; GEMM has no polynomial so it reads as zero.
  always_comb begin
    coef_o = '0;
    for (int i = 0; i <= UNO_DEPTH; i++) begin
      case (op_i)
        OP_DIV:  coef_o[i] = COEF_DIV[i];
        OP_EXP:  coef_o[i] = COEF_EXP[i];
        OP_LOG:  coef_o[i] = COEF_LOG[i];
        default: coef_o[i] = '0;
      endcase
    end
  end

endmodule

// File: rtl/uno_horner_seq.sv
// uno_horner_seq
//   Sequencer feeding a PE row that evaluates unary ops as Horner polynomials.
//   Holds one coefficient per PE column on wc_col, streams operands into PE0
//   on var_seed, and follows one cycle later with the leading-coefficient seed
//   on mac_seed. res_valid marks the cycle the last PE's mac_o is valid.
//   Ports:
//     clk, rst              : clock, synchronous active-high reset
//     req_valid/ready/op/cnt: op request (accepted only in IDLE)
//     x_valid/ready/data    : operand stream, left-aligned Q(INT.FRA)
//     gemm_uno              : mode broadcast to the PE row
//     wc_col                : slice k = coefficient for column k
//     var_seed, mac_seed    : PE0 var_i / mac_i
//     res_valid, busy, done : result strobe, FSM not idle, end-of-op pulse
//   Optional build macro UNO_SEQ_PERF_EN adds saturating counters
//   perf_ops (results produced) and perf_stall (STREAM cycles without x_valid).
module uno_horner_seq
  import raven_uno_pkg::*;
#(
  parameter int INT_BW = UNO_INT_BW,
  parameter int FRA_BW = UNO_FRA_BW,
  parameter int MUL_BW = UNO_MUL_BW,
  parameter int ACC_BW = UNO_ACC_BW,
  parameter int DEPTH  = UNO_DEPTH,
  parameter int ROWS   = UNO_ROWS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_op,
  input  logic [15:0]             req_cnt,
  input  logic                    x_valid,
  output logic                    x_ready,
  input  logic [MUL_BW-1:0]       x_data,
  output logic [1:0]              gemm_uno,
  output logic [DEPTH*MUL_BW-1:0] wc_col,
  output logic [MUL_BW-1:0]       var_seed,
  output logic [ACC_BW-1:0]       mac_seed,
  output logic                    res_valid,
  output logic                    busy,
  output logic                    done
`ifdef UNO_SEQ_PERF_EN
  ,
  output logic [31:0]             perf_ops,
  output logic [31:0]             perf_stall
`endif
);

  localparam int CW = INT_BW + FRA_BW + 1;
  localparam int LW = $clog2(ROWS + 2);

  uno_state_e                state_q;
  logic [15:0]               rem_q;
  logic [LW-1:0]             loadCnt_q;
  logic [DEPTH+1:0]          validSr_q;
  logic [DEPTH*MUL_BW-1:0]   wcCol_q, wcCol_d;
  logic [ACC_BW-1:0]         seed_q, seed_d;
  logic [MUL_BW-1:0]         varSeed_q;
  logic [ACC_BW-1:0]         macSeed_q;
  logic [1:0]                gemmUno_q;
  logic                      reqReady_q, xReady_q, busy_q, done_q;
  logic [DEPTH:0][CW-1:0]    romCoef;
  logic                      xHs;

  // The ROM is addressed by the incoming request so the coefficients can be
  // captured in the same edge that accepts the op.
  uno_coef_rom u_rom (
    .op_i   (uno_op_e'(req_op)),
    .coef_o (romCoef)
  );

  // Column k sees coefficient DEPTH-1-k left-aligned in the multiplier word;
  // the mac seed is the leading coefficient widened to accumulator scale.
  always_comb begin
    wcCol_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      wcCol_d[k*MUL_BW +: MUL_BW] = {romCoef[DEPTH-1-k], {(MUL_BW-CW){1'b0}}};
    end
    seed_d = {{(ACC_BW-CW-FRA_BW){romCoef[DEPTH][CW-1]}}, romCoef[DEPTH], {FRA_BW{1'b0}}};
  end

  assign xHs = x_valid && xReady_q;

  // Main sequencer. The valid shift register tracks each accepted operand
  // down the row: bit 0 lines up with var_seed, bit DEPTH+1 with the
  // last PE's result. The mac seed trails var by one cycle for the PE vreg.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      loadCnt_q  <= '0;
      validSr_q  <= '0;
      wcCol_q    <= '0;
      seed_q     <= '0;
      varSeed_q  <= '0;
      macSeed_q  <= '0;
      gemmUno_q  <= 2'b00;
      reqReady_q <= 1'b1;
      xReady_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      validSr_q <= {validSr_q[DEPTH:0], xHs};
      varSeed_q <= xHs ? x_data : '0;
      macSeed_q <= validSr_q[0] ? seed_q : '0;
      done_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            if (req_op == OP_GEMM) begin
              gemmUno_q <= OP_GEMM;
            end else begin
              gemmUno_q  <= req_op;
              rem_q      <= req_cnt;
              loadCnt_q  <= '0;
              wcCol_q    <= wcCol_d;
              seed_q     <= seed_d;
              reqReady_q <= 1'b0;
              busy_q     <= 1'b1;
              state_q    <= ST_LOAD;
            end
          end
        end
        // Give the wc pipeline and PE weight register time to settle.
        ST_LOAD: begin
          if (loadCnt_q == LW'(ROWS)) begin
            if (rem_q == 16'd0) begin
              state_q <= ST_DRAIN;
            end else begin
              state_q  <= ST_STREAM;
              xReady_q <= 1'b1;
            end
          end else begin
            loadCnt_q <= loadCnt_q + LW'(1);
          end
        end
        ST_STREAM: begin
          if (xHs) begin
            rem_q <= rem_q - 16'd1;
            if (rem_q == 16'd1) begin
              state_q  <= ST_DRAIN;
              xReady_q <= 1'b0;
            end
          end
        end
        // Leave once the only bit left (if any) is the result emerging now.
        ST_DRAIN: begin
          if (validSr_q[DEPTH:0] == '0) begin
            state_q    <= ST_IDLE;
            gemmUno_q  <= OP_GEMM;
            wcCol_q    <= '0;
            seed_q     <= '0;
            reqReady_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = reqReady_q;
  assign x_ready   = xReady_q;
  assign gemm_uno  = gemmUno_q;
  assign wc_col    = wcCol_q;
  assign var_seed  = varSeed_q;
  assign mac_seed  = macSeed_q;
  assign res_valid = validSr_q[DEPTH+1];
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef UNO_SEQ_PERF_EN
  logic [31:0] perfOps_q, perfStall_q;

  // Saturating activity counters for throughput analysis.
  always_ff @(posedge clk) begin
    if (rst) begin
      perfOps_q   <= '0;
      perfStall_q <= '0;
    end else begin
      if (validSr_q[DEPTH+1] && perfOps_q != '1) begin
        perfOps_q <= perfOps_q + 32'd1;
      end
      if (state_q == ST_STREAM && !x_valid && perfStall_q != '1) begin
        perfStall_q <= perfStall_q + 32'd1;
      end
    end
  end

  assign perf_ops   = perfOps_q;
  assign perf_stall = perfStall_q;
`endif

endmodule

// File: tb/tb_uno_horner_seq.sv
// tb_uno_horner_seq
//   Directed bench for uno_horner_seq. Stimulus pushes expected seed values
//   and result/done cycles into queues; a monitor pops them when the DUT
//   presents the corresponding output.
module tb_uno_horner_seq;

  localparam int DEPTH  = 8;
  localparam int MUL_BW = 16;
  localparam int ACC_BW = 32;

  logic                    clk;
  logic                    rst;
  logic                    req_valid;
  logic                    req_ready;
  logic [1:0]              req_op;
  logic [15:0]             req_cnt;
  logic                    x_valid;
  logic                    x_ready;
  logic [MUL_BW-1:0]       x_data;
  logic [1:0]              gemm_uno;
  logic [DEPTH*MUL_BW-1:0] wc_col;
  logic [MUL_BW-1:0]       var_seed;
  logic [ACC_BW-1:0]       mac_seed;
  logic                    res_valid;
  logic                    busy;
  logic                    done;
`ifdef UNO_SEQ_PERF_EN
  logic [31:0]             perf_ops;
  logic [31:0]             perf_stall;
`endif

  uno_horner_seq dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_cnt   (req_cnt),
    .x_valid   (x_valid),
    .x_ready   (x_ready),
    .x_data    (x_data),
    .gemm_uno  (gemm_uno),
    .wc_col    (wc_col),
    .var_seed  (var_seed),
    .mac_seed  (mac_seed),
    .res_valid (res_valid),
    .busy      (busy),
    .done      (done)
`ifdef UNO_SEQ_PERF_EN
    ,
    .perf_ops  (perf_ops),
    .perf_stall(perf_stall)
`endif
  );

  // Hand-computed coefficient images (left-aligned, column 7 leftmost).
  localparam logic [127:0] WC_EXP = 128'h0400_0400_0200_00C0_0040_0000_0000_0000;
  localparam logic [127:0] WC_LOG = 128'h0000_0400_FE00_0140_FF00_00C0_FF40_0080;
  localparam logic [127:0] WC_DIV = 128'h0400_FC00_0400_FC00_0400_FC00_0400_FC00;
  localparam logic [31:0]  SEED_DIV = 32'h0000_0100;
  localparam logic [31:0]  SEED_EXP = 32'h0000_0000;
  localparam logic [31:0]  SEED_LOG = 32'hFFFF_FFE0;

  typedef struct packed {
    int          t;
    logic [31:0] v;
  } exp_t;

  int   cyc = 0;
  int   vecCount = 0;
  int   missCount = 0;
  int   resQ[$];
  int   doneQ[$];
  exp_t varQ[$];
  exp_t macQ[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single place where comparisons are counted and failures reported.
  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: sample just after each edge and retire queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (res_valid === 1'b1) begin
        if (resQ.size() == 0) checkOutput("res_valid unexpected", 1, 0);
        else checkOutput("res_valid cycle", cyc, resQ.pop_front());
      end
      if (done === 1'b1) begin
        if (doneQ.size() == 0) checkOutput("done unexpected", 1, 0);
        else checkOutput("done cycle", cyc, doneQ.pop_front());
      end
      if (varQ.size() > 0 && varQ[0].t == cyc) begin
        e = varQ.pop_front();
        checkOutput("var_seed", var_seed, e.v[MUL_BW-1:0]);
      end
      if (macQ.size() > 0 && macQ[0].t == cyc) begin
        e = macQ.pop_front();
        checkOutput("mac_seed", mac_seed, e.v);
      end
    end
  end

  // Issue one request; returns the cycle it was presented in.
  task automatic applyStimulus(input logic [1:0] op, input logic [15:0] cnt, output int acc);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready) checkOutput("req_ready timeout", 0, 1);
    req_valid = 1'b1;
    req_op    = op;
    req_cnt   = cnt;
    acc       = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_cnt   = 16'd0;
  endtask

  // Present one operand, record expectations, then idle for gap cycles.
  task automatic sendOperand(input logic [15:0] data, input logic [31:0] seed,
                             input int gap, output int t);
    int n = 0;
    exp_t e;
    t = -1;
    while (!x_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!x_ready) begin
      checkOutput("x_ready timeout", 0, 1);
    end else begin
      x_valid = 1'b1;
      x_data  = data;
      t       = cyc;
      e.t = t + 1; e.v = {16'h0, data}; varQ.push_back(e);
      e.t = t + 2; e.v = seed;          macQ.push_back(e);
      resQ.push_back(t + 2 + DEPTH);
      @(negedge clk);
      x_valid = 1'b0;
      x_data  = '0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic waitIdle();
    int n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (busy) checkOutput("busy timeout", 1, 0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    int a, t, t0;
    rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_cnt = 16'd0;
    x_valid = 1'b0; x_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("reset busy", busy, 0);
    checkOutput("reset req_ready", req_ready, 1);
    checkOutput("reset x_ready", x_ready, 0);
    checkOutput("reset gemm_uno", gemm_uno, 0);
    checkOutput("reset wc_col", wc_col, 0);
    checkOutput("reset seeds", {var_seed, mac_seed}, 0);
    checkOutput("reset res/done", {res_valid, done}, 0);

    $display("[TB] gemm request");
    applyStimulus(2'b00, 16'd5, a);
    checkOutput("gemm gemm_uno", gemm_uno, 0);
    checkOutput("gemm busy", busy, 0);
    checkOutput("gemm x_ready", x_ready, 0);
    checkOutput("gemm req_ready", req_ready, 1);

    $display("[TB] exp cnt=1 x=0");
    applyStimulus(2'b10, 16'd1, a);
    checkOutput("exp busy", busy, 1);
    checkOutput("exp req_ready", req_ready, 0);
    checkOutput("exp gemm_uno", gemm_uno, 2'b10);
    checkOutput("exp wc_col", wc_col, WC_EXP);
    // With x=0 the Horner result collapses to the x^0 coefficient (1.0).
    checkOutput("exp pe result", wc_col[127:118], 10'h010);
    sendOperand(16'h0000, SEED_EXP, 0, t);
    checkOutput("exp load length", t, a + 3);
    doneQ.push_back(t + DEPTH + 3);
    waitIdle();

    $display("[TB] log cnt=3 back-to-back");
    applyStimulus(2'b11, 16'd3, a);
    checkOutput("log wc_col", wc_col, WC_LOG);
    sendOperand(16'h1000, SEED_LOG, 0, t0);
    sendOperand(16'h2000, SEED_LOG, 0, t);
    sendOperand(16'h3000, SEED_LOG, 0, t);
    checkOutput("log back-to-back", t, t0 + 2);
    checkOutput("log busy", busy, 1);
    doneQ.push_back(t + DEPTH + 3);
    waitIdle();

    $display("[TB] reset mid-stream");
    applyStimulus(2'b01, 16'd5, a);
    sendOperand(16'h0A00, SEED_DIV, 0, t);
    sendOperand(16'h0B00, SEED_DIV, 0, t);
    rst = 1'b1;
    resQ.delete(); varQ.delete(); macQ.delete();
    @(negedge clk);
    checkOutput("abort busy", busy, 0);
    checkOutput("abort req_ready", req_ready, 1);
    checkOutput("abort outputs", {x_ready, gemm_uno, wc_col, var_seed, mac_seed, res_valid, done}, 0);
    rst = 1'b0;

    $display("[TB] div cnt=4 with gaps");
    applyStimulus(2'b01, 16'd4, a);
    checkOutput("div wc_col", wc_col, WC_DIV);
    sendOperand(16'h0100, SEED_DIV, 1, t);
    sendOperand(16'h0200, SEED_DIV, 1, t);
    sendOperand(16'h0300, SEED_DIV, 1, t);
    sendOperand(16'h0400, SEED_DIV, 0, t);
    doneQ.push_back(t + DEPTH + 3);
    waitIdle();
`ifdef UNO_SEQ_PERF_EN
    checkOutput("perf_stall", perf_stall, 3);
    checkOutput("perf_ops", perf_ops, 4);
`endif

    $display("[TB] exp cnt=0");
    applyStimulus(2'b10, 16'd0, a);
    doneQ.push_back(a + 4);
    req_valid = 1'b1; req_op = 2'b01; req_cnt = 16'd2;
    checkOutput("busy req_ready", req_ready, 0);
    @(negedge clk);
    req_valid = 1'b0; req_op = 2'b00; req_cnt = 16'd0;
    checkOutput("cnt0 gemm_uno", gemm_uno, 2'b10);
    waitIdle();
    repeat (3) @(negedge clk);
    checkOutput("cnt0 stays idle", busy, 0);
    checkOutput("cnt0 wc cleared", wc_col, 0);

    checkOutput("res pending", resQ.size(), 0);
    checkOutput("done pending", doneQ.size(), 0);
    checkOutput("seed pending", varQ.size() + macQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
